multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control FSM for the multicycle variant of the RV32I core. It sequences a single shared ALU, a single unified memory port, and the register file across instruction phases. It combines the main-decoder opcode classes with a state machine. It also waits on a memory ready/valid handshake, so slow memory stalls the datapath cleanly instead of corrupting it.

Parameters:
- STATE_W, 4, width of state register; fixed encodings below, must be >= 4.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- Op  input  7  opcode field of the instruction register (instr[6:0]).
- Zero  input  1  ALU zero flag, same cycle.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request strobe; held until mem_ready.
- AdrSrc  output  1  0 = PC, 1 = ALUOut drives memory address.
- IRWrite  output  1  load instruction register / OldPC.
- PCWrite  output  1  PC enable, equal to PCUpdate | (Branch & Zero).
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  memory write enable.
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4.
- ALUOp  output  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded.
- ImmSrc  output  2  combinational from Op: sw 01, beq 10, jal 11, else 00.
- illegal_op  output  1  one-cycle pulse on unsupported opcode.

Behaviour:
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, BEQ 10, JAL 11. Any other encoding returns to FETCH next cycle with all outputs 0.
- Reset (rst=0): state goes to IDLE immediately, independent of the clock. All outputs are 0 while in IDLE. IDLE moves to FETCH on the first rising edge after reset release.
- Outputs are Moore, decoded from the state, except for the mem_ready gating and the PCWrite term. Every output not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are 1 only in the cycle mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00 to compute the branch target.
  - Next state by Op: 0000011/0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BEQ, 1101111 to JAL.
  - Any other Op returns to FETCH and pulses illegal_op=1 for that cycle. No register or memory write occurs.
- MEMADR: drives ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if Op=0000011, else MEMWRITE.
- MEMREAD: drives mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: drives ResultSrc=01, RegWrite=1, then goes to FETCH.
- MEMWRITE:
  - Drives mem_req=1, AdrSrc=1, ResultSrc=00.
  - MemWrite=1 is held, with address and data stable, until mem_ready=1; then goes to FETCH.
- EXECR: drives ALUSrcA=10, ALUSrcB=00, ALUOp=10, then goes to ALUWB.
- EXECI: drives ALUSrcA=10, ALUSrcB=01, ALUOp=10, then goes to ALUWB.
- ALUWB: drives ResultSrc=00, RegWrite=1, then goes to FETCH.
- BEQ:
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - PCWrite equals Zero. Goes to FETCH.
- JAL: drives ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then goes to ALUWB.
- Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R/I-type 4, beq 3, jal 4.
- mem_ready outside a request state is ignored.
- Reset asserted mid-instruction abandons that instruction: no partial RegWrite or MemWrite.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - Adds output cycle_cnt[31:0], which increments every non-IDLE cycle.
  - Adds output instret_cnt[31:0], which increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both counters wrap at 2^32 and reset to 0 on rst.
  - Illegal opcodes do not increment instret_cnt.
- Undefined: the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset release, mem_ready=1, Op=0000011 (lw): from FETCH, state sequence is FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. RegWrite=1 and ResultSrc=01 only in cycle 5.
- FETCH with mem_ready low for 3 cycles: mem_req=1 for 4 cycles. IRWrite and PCWrite are 1 only in cycle 4, and DECODE follows in cycle 5.
- Op=1100011 (beq): PCWrite=1 in BEQ when Zero=1 and 0 when Zero=0. Both cases return to FETCH after 3 cycles.
- Op=0100011 (sw) with mem_ready low for 2 cycles in MEMWRITE: MemWrite=1 and AdrSrc=1 held for 3 cycles, and RegWrite stays 0 throughout.
- Op=1111111: illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no write strobes. With MULTICYCLE_CTRL_PERF_EN, instret_cnt is unchanged.
- rst asserted during MEMREAD: all outputs are 0 immediately. After release: IDLE for 1 cycle, then FETCH. With MULTICYCLE_CTRL_PERF_EN, the counters read 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RV32I core.
// Sequences one shared ALU, one unified memory port and the register file
// through the fetch/decode/execute/writeback phases of each instruction.
// Memory accesses wait on a mem_req/mem_ready handshake, so a slow memory
// stalls the datapath without corrupting it.
//
// Optional build macro: MULTICYCLE_CTRL_PERF_EN
//   When defined, adds cycle_cnt (non-IDLE cycles) and instret_cnt
//   (retired instructions) performance counters as extra outputs.
//
// STATE_W sets the state register width; the fixed encodings need >= 4.

module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       illegal_op
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   // Opcode classes recognised by the main decoder
   localparam logic [6:0] opLoad   = 7'b0000011;
   localparam logic [6:0] opStore  = 7'b0100011;
   localparam logic [6:0] opRType  = 7'b0110011;
   localparam logic [6:0] opIType  = 7'b0010011;
   localparam logic [6:0] opBranch = 7'b1100011;
   localparam logic [6:0] opJal    = 7'b1101111;

   // Fixed state encodings; unused codes fall back to FETCH
   typedef enum logic [STATE_W-1:0] {
      IDLE     = STATE_W'(0),
      FETCH    = STATE_W'(1),
      DECODE   = STATE_W'(2),
      MEMADR   = STATE_W'(3),
      MEMREAD  = STATE_W'(4),
      MEMWB    = STATE_W'(5),
      MEMWRITE = STATE_W'(6),
      EXECR    = STATE_W'(7),
      EXECI    = STATE_W'(8),
      ALUWB    = STATE_W'(9),
      BEQ      = STATE_W'(10),
      JAL      = STATE_W'(11)
   } stateT;

   stateT      state;
   stateT      nextState;
   logic       pcUpdate;
   logic       branch;
   logic       immEnable;
   logic [1:0] immDecoded;
   logic       isLoad;
   logic       isStore;
   logic       isRType;
   logic       isIType;
   logic       isBranch;
   logic       isJal;

   // Opcode class flags shared by the next-state and immediate decoders
   always_comb begin
      isLoad   = (Op == opLoad);
      isStore  = (Op == opStore);
      isRType  = (Op == opRType);
      isIType  = (Op == opIType);
      isBranch = (Op == opBranch);
      isJal    = (Op == opJal);
   end

   // State register; reset abandons any in-flight instruction at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and Moore output decode; only the FETCH strobes, the
   // memory-stall holds and the branch PC term look at live inputs
   always_comb begin
      nextState  = state;
      mem_req    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      illegal_op = 1'b0;
      pcUpdate   = 1'b0;
      branch     = 1'b0;
      immEnable  = 1'b1;

      case (state)
         IDLE: begin
            immEnable = 1'b0;
            nextState = FETCH;
         end

         FETCH: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b00;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            pcUpdate  = mem_ready;
            if (mem_ready) begin
               nextState = DECODE;
            end
         end

         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b00;
            if (isLoad || isStore) begin
               nextState = MEMADR;
            end else if (isRType) begin
               nextState = EXECR;
            end else if (isIType) begin
               nextState = EXECI;
            end else if (isBranch) begin
               nextState = BEQ;
            end else if (isJal) begin
               nextState = JAL;
            end else begin
               illegal_op = 1'b1;
               nextState  = FETCH;
            end
         end

         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b00;
            if (isLoad) begin
               nextState = MEMREAD;
            end else begin
               nextState = MEMWRITE;
            end
         end

         MEMREAD: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b1;
            ResultSrc = 2'b00;
            if (mem_ready) begin
               nextState = MEMWB;
            end
         end

         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            nextState = FETCH;
         end

         MEMWRITE: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b1;
            ResultSrc = 2'b00;
            MemWrite  = 1'b1;
            if (mem_ready) begin
               nextState = FETCH;
            end
         end

         EXECR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b00;
            ALUOp     = 2'b10;
            nextState = ALUWB;
         end

         EXECI: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ALUOp     = 2'b10;
            nextState = ALUWB;
         end

         ALUWB: begin
            ResultSrc = 2'b00;
            RegWrite  = 1'b1;
            nextState = FETCH;
         end

         BEQ: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b00;
            ALUOp     = 2'b01;
            ResultSrc = 2'b00;
            branch    = 1'b1;
            nextState = FETCH;
         end

         JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b00;
            ResultSrc = 2'b00;
            pcUpdate  = 1'b1;
            nextState = ALUWB;
         end

         default: begin
            immEnable = 1'b0;
            nextState = FETCH;
         end
      endcase
   end

   // PC enable merges unconditional updates with a taken branch
   assign PCWrite = pcUpdate | (branch & Zero);

   // Immediate format select straight from the opcode, silenced in IDLE
   // and in unused encodings so those states drive all-zero outputs
   always_comb begin
      immDecoded = 2'b00;
      if (isStore) begin
         immDecoded = 2'b01;
      end else if (isBranch) begin
         immDecoded = 2'b10;
      end else if (isJal) begin
         immDecoded = 2'b11;
      end
      ImmSrc = immEnable ? immDecoded : 2'b00;
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic instRetire;

   // An instruction retires when its final state hands back to FETCH
   always_comb begin
      instRetire = (nextState == FETCH) &&
                   ((state == MEMWB) || (state == MEMWRITE) ||
                    (state == ALUWB) || (state == BEQ));
   end

   // Free-running performance counters, wrapping at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt   <= 32'd0;
         instret_cnt <= 32'd0;
      end else begin
         if (state != IDLE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         if (instRetire) begin
            instret_cnt <= instret_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for the
// multicycle control FSM. Outputs are packed into one vector and compared
// against hand-built per-state expectations one cycle at a time.

module tb_multicycle_controller;

   logic        clk;
   logic        rst;
   logic [6:0]  Op;
   logic        Zero;
   logic        mem_ready;
   logic        mem_req;
   logic        AdrSrc;
   logic        IRWrite;
   logic        PCWrite;
   logic        RegWrite;
   logic        MemWrite;
   logic [1:0]  ResultSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUOp;
   logic [1:0]  ImmSrc;
   logic        illegal_op;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;
`endif

   int compareCount = 0;
   int failCount    = 0;
   int stimCount    = 0;

   logic [16:0] outVec;
   logic [16:0] fWait, fGo, dec, decIll, mAdr, mRd, mWb, mWr;
   logic [16:0] exR, exI, aWb, beqT, beqN, jalV;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RTY  = 7'b0110011;
   localparam logic [6:0] ITY  = 7'b0010011;
   localparam logic [6:0] BEQO = 7'b1100011;
   localparam logic [6:0] JALO = 7'b1101111;
   localparam logic [6:0] BAD  = 7'b1111111;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .Op         (Op),
      .Zero       (Zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .ImmSrc     (ImmSrc),
      .illegal_op (illegal_op)
`ifdef MULTICYCLE_CTRL_PERF_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt)
`endif
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign outVec = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op};

   function automatic logic [16:0] mk(input logic req, input logic adr,
                                      input logic irw, input logic pcw,
                                      input logic rw, input logic mw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] aop,
                                      input logic ill);
      return {req, adr, irw, pcw, rw, mw, rs, sa, sb, aop, 2'b00, ill};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and check the outputs
   task automatic applyStimulus(input string tag, input logic [6:0] opV,
                                input logic zeroV, input logic readyV,
                                input logic [16:0] baseV, input logic [1:0] immV);
      logic [16:0] expV;
      @(negedge clk);
      Op        = opV;
      Zero      = zeroV;
      mem_ready = readyV;
      #1;
      expV = baseV | {14'd0, immV, 1'b0};
      checkOutput(tag, {15'd0, outVec}, {15'd0, expV});
      stimCount++;
`ifdef MULTICYCLE_CTRL_PERF_EN
      checkOutput({tag, ".cyc"}, cycle_cnt, 32'(stimCount - 1));
`endif
   endtask

   initial begin
      fWait  = mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0);
      fGo    = mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,0);
      dec    = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0);
      decIll = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,1);
      mAdr   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0);
      mRd    = mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0);
      mWb    = mk(0,0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,0);
      mWr    = mk(1,1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
      exR    = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
      exI    = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0);
      aWb    = mk(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0);
      beqT   = mk(0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b01,0);
      beqN   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0);
      jalV   = mk(0,0,0,1,0,0,2'b00,2'b01,2'b10,2'b00,0);

      rst = 1'b0; Op = LW; Zero = 1'b0; mem_ready = 1'b1;
      #3;
      checkOutput("resetOut", {15'd0, outVec}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("idleOut", {15'd0, outVec}, 32'd0);
      rst = 1'b1;
      stimCount = 0;

      // lw with a ready memory
      applyStimulus("lw.fetch",  LW, 0, 1, fGo,  2'b00);
      applyStimulus("lw.decode", LW, 0, 1, dec,  2'b00);
      applyStimulus("lw.memadr", LW, 0, 1, mAdr, 2'b00);
      applyStimulus("lw.memrd",  LW, 0, 1, mRd,  2'b00);
      applyStimulus("lw.memwb",  LW, 0, 1, mWb,  2'b00);

      // fetch stalled three cycles, then an R-type
      applyStimulus("r.fwait0",  RTY, 0, 0, fWait, 2'b00);
`ifdef MULTICYCLE_CTRL_PERF_EN
      checkOutput("instret.lw", instret_cnt, 32'd1);
`endif
      applyStimulus("r.fwait1",  RTY, 0, 0, fWait, 2'b00);
      applyStimulus("r.fwait2",  RTY, 0, 0, fWait, 2'b00);
      applyStimulus("r.fetch",   RTY, 0, 1, fGo,   2'b00);
      applyStimulus("r.decode",  RTY, 0, 1, dec,   2'b00);
      applyStimulus("r.execr",   RTY, 0, 1, exR,   2'b00);
      applyStimulus("r.aluwb",   RTY, 0, 1, aWb,   2'b00);

      // beq taken then not taken
      applyStimulus("beqT.fetch",  BEQO, 1, 1, fGo,  2'b10);
      applyStimulus("beqT.decode", BEQO, 1, 1, dec,  2'b10);
      applyStimulus("beqT.beq",    BEQO, 1, 1, beqT, 2'b10);
      applyStimulus("beqN.fetch",  BEQO, 0, 1, fGo,  2'b10);
      applyStimulus("beqN.decode", BEQO, 0, 1, dec,  2'b10);
      applyStimulus("beqN.beq",    BEQO, 0, 1, beqN, 2'b10);

      // sw with memory stalled two cycles in MEMWRITE
      applyStimulus("sw.fetch",  SW, 0, 1, fGo,  2'b01);
      applyStimulus("sw.decode", SW, 0, 1, dec,  2'b01);
      applyStimulus("sw.memadr", SW, 0, 1, mAdr, 2'b01);
      applyStimulus("sw.memwr0", SW, 0, 0, mWr,  2'b01);
      applyStimulus("sw.memwr1", SW, 0, 0, mWr,  2'b01);
      applyStimulus("sw.memwr2", SW, 0, 1, mWr,  2'b01);

      // I-type
      applyStimulus("i.fetch",  ITY, 0, 1, fGo, 2'b00);
      applyStimulus("i.decode", ITY, 0, 1, dec, 2'b00);
      applyStimulus("i.execi",  ITY, 0, 1, exI, 2'b00);
      applyStimulus("i.aluwb",  ITY, 0, 1, aWb, 2'b00);

      // jal
      applyStimulus("jal.fetch",  JALO, 0, 1, fGo,  2'b11);
      applyStimulus("jal.decode", JALO, 0, 1, dec,  2'b11);
      applyStimulus("jal.jal",    JALO, 0, 1, jalV, 2'b11);
      applyStimulus("jal.aluwb",  JALO, 0, 1, aWb,  2'b11);

      // illegal opcode: one-cycle pulse, back to FETCH, nothing retired
      applyStimulus("bad.fetch",  BAD, 0, 1, fGo,    2'b00);
`ifdef MULTICYCLE_CTRL_PERF_EN
      checkOutput("instret.pre", instret_cnt, 32'd7);
`endif
      applyStimulus("bad.decode", BAD, 0, 1, decIll, 2'b00);
      applyStimulus("bad.fetch2", BAD, 0, 0, fWait,  2'b00);
`ifdef MULTICYCLE_CTRL_PERF_EN
      checkOutput("instret.bad", instret_cnt, 32'd7);
`endif

      // reset asserted mid-MEMREAD
      applyStimulus("rs.fetch",  LW, 0, 1, fGo,  2'b00);
      applyStimulus("rs.decode", LW, 0, 1, dec,  2'b00);
      applyStimulus("rs.memadr", LW, 0, 1, mAdr, 2'b00);
      applyStimulus("rs.memrd",  LW, 0, 0, mRd,  2'b00);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("rs.async", {15'd0, outVec}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
      checkOutput("rs.cyc0", cycle_cnt, 32'd0);
      checkOutput("rs.ins0", instret_cnt, 32'd0);
`endif
      @(negedge clk);
      #1;
      checkOutput("rs.held", {15'd0, outVec}, 32'd0);
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      checkOutput("rs.idle", {15'd0, outVec}, 32'd0);
      stimCount = 0;
      applyStimulus("rs2.fetch",  RTY, 0, 1, fGo, 2'b00);
      applyStimulus("rs2.decode", RTY, 0, 1, dec, 2'b00);
      applyStimulus("rs2.execr",  RTY, 0, 1, exR, 2'b00);
      applyStimulus("rs2.aluwb",  RTY, 0, 1, aWb, 2'b00);
      applyStimulus("rs2.fetch2", RTY, 0, 0, fWait, 2'b00);
`ifdef MULTICYCLE_CTRL_PERF_EN
      checkOutput("rs2.instret", instret_cnt, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
